// File: rtl/pipe_select_mux.sv
// N-way select stage with a registered output and a 2-entry skid buffer.
// Select resolution happens per input lane on the input side. The resolved
// {data, err} word is then queued through OUT/SKID behind a valid/ready handshake.

// One input lane: decides whether this lane is the one selected and passes its data on.
module pipe_select_lane #(
  parameter int WIDTH  = 32,
  parameter int SEL_W  = 2,
  parameter int ONEHOT = 0,
  parameter int IDX    = 0
) (
  input  logic [SEL_W-1:0] sel,
  input  logic [WIDTH-1:0] din,
  output logic             hit,
  output logic [WIDTH-1:0] dout
);
  generate
    if (ONEHOT != 0) begin : g_oh
      // Lowest set bit wins, so this lane hits only when every lower bit is clear.
      localparam logic [SEL_W-1:0] LOW = SEL_W'((1 << IDX) - 1);
      assign hit = sel[IDX] & ~|(sel & LOW);
    end else begin : g_bin
      assign hit = (sel == SEL_W'(IDX));
    end
  endgenerate

  assign dout = hit ? din : '0;
endmodule

module pipe_select_mux #(
  parameter int WIDTH  = 32,
  parameter int NUM_IN = 4,
  parameter int ONEHOT = 0,
  parameter int SEL_W  = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]        in_sel,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_err,
  output logic                    out_valid,
  input  logic                    out_ready
);
  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic             err;
  } word_t;

  localparam logic [1:0] EMPTY = 2'd0;
  localparam logic [1:0] ONE   = 2'd1;
  localparam logic [1:0] FULL  = 2'd2;

  logic [NUM_IN-1:0]            hit;
  logic [NUM_IN-1:0][WIDTH-1:0] lane_d;
  word_t                        res;
  word_t                        out_q, skid_q;
  logic [1:0]                   state;
  logic                         in_x, out_x;

  genvar i;
  generate
    for (i = 0; i < NUM_IN; i++) begin : g_lane
      pipe_select_lane #(
        .WIDTH(WIDTH), .SEL_W(SEL_W), .ONEHOT(ONEHOT), .IDX(i)
      ) u_lane (
        .sel  (in_sel),
        .din  (in_data[i*WIDTH +: WIDTH]),
        .hit  (hit[i]),
        .dout (lane_d[i])
      );
    end
  endgenerate

  // At most one lane hits, so OR-ing the masked lanes gives the selected word.
  // No hit means an illegal select: data reads as zero and err is raised.
  always_comb begin
    res.data = '0;
    for (int k = 0; k < NUM_IN; k++) res.data = res.data | lane_d[k];
    res.err = ~|hit;
  end

  assign in_x  = in_valid & in_ready;
  assign out_x = out_valid & out_ready;

  // Occupancy FSM moving words through OUT and SKID. OUT is cleared when the
  // stage drains, so out_err cannot be seen set while out_valid is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= EMPTY;
      out_q  <= '0;
      skid_q <= '0;
    end else begin
      case (state)
        EMPTY: if (in_x) begin
          out_q <= res;
          state <= ONE;
        end
        ONE: begin
          if (in_x && out_x) out_q <= res;
          else if (in_x) begin
            skid_q <= res;
            state  <= FULL;
          end else if (out_x) begin
            out_q <= '0;
            state <= EMPTY;
          end
        end
        FULL: if (out_x) begin
          out_q  <= skid_q;
          skid_q <= '0;
          state  <= ONE;
        end
        default: state <= EMPTY;
      endcase
    end
  end

  // in_ready depends only on the state register, never on out_ready.
  assign in_ready  = (state != FULL);
  assign out_valid = (state != EMPTY);
  assign out_data  = out_q.data;
  assign out_err   = out_q.err;
endmodule

// File: tb/tb_pipe_select_mux.sv
// Bench for pipe_select_mux. Three instances run side by side: a 4-way binary
// one, a 3-way binary one (so illegal indices exist) and a 4-way one-hot one.
// Each instance has a FIFO model of up to two words.
module tb_pipe_select_mux;
  typedef struct packed {
    logic [31:0] d;
    logic        e;
  } word_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [127:0] din = '0;
  logic [3:0]   sel = '0;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;

  logic        ir_b, ov_b, oe_b, ir_o, ov_o, oe_o, ir_h, ov_h, oe_h;
  logic [31:0] od_b, od_o, od_h;

  int n_chk = 0;
  int n_fail = 0;
  word_t q0[$], q1[$], q2[$];

  always #5 clk = ~clk;

  pipe_select_mux #(.WIDTH(32), .NUM_IN(4), .ONEHOT(0), .SEL_W(2)) u_bin (
    .clk(clk), .rst_n(rst_n), .in_data(din), .in_sel(sel[1:0]), .in_valid(in_valid),
    .in_ready(ir_b), .out_data(od_b), .out_err(oe_b), .out_valid(ov_b), .out_ready(out_ready));
  pipe_select_mux #(.WIDTH(32), .NUM_IN(3), .ONEHOT(0), .SEL_W(2)) u_odd (
    .clk(clk), .rst_n(rst_n), .in_data(din[95:0]), .in_sel(sel[1:0]), .in_valid(in_valid),
    .in_ready(ir_o), .out_data(od_o), .out_err(oe_o), .out_valid(ov_o), .out_ready(out_ready));
  pipe_select_mux #(.WIDTH(32), .NUM_IN(4), .ONEHOT(1), .SEL_W(4)) u_oh (
    .clk(clk), .rst_n(rst_n), .in_data(din), .in_sel(sel), .in_valid(in_valid),
    .in_ready(ir_h), .out_data(od_h), .out_err(oe_h), .out_valid(ov_h), .out_ready(out_ready));

  // Select semantics taken directly from the rules: an index, or the lowest set bit.
  function automatic word_t resolve(input int n, input bit oh, input logic [3:0] s,
                                    input logic [127:0] d);
    word_t r;
    r = '{d: 32'h0, e: 1'b1};
    if (!oh) begin
      if (int'(s) < n) r = '{d: d[int'(s)*32 +: 32], e: 1'b0};
    end else begin
      for (int k = n - 1; k >= 0; k--)
        if (s[k]) r = '{d: d[k*32 +: 32], e: 1'b0};
    end
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h, expected %h", nm, $time, act, exp);
    end
  endtask

  task automatic cmp(input string nm, input logic ov, input logic ir, input logic [31:0] od,
                     input logic oe, input int sz, input word_t hd);
    chk({nm, ".out_valid"}, 32'(ov), 32'(sz > 0));
    chk({nm, ".in_ready"}, 32'(ir), 32'(sz < 2));
    if (sz > 0) begin
      chk({nm, ".out_data"}, od, hd.d);
      chk({nm, ".out_err"}, 32'(oe), 32'(hd.e));
    end else begin
      chk({nm, ".out_err_idle"}, 32'(oe), 32'h0);
    end
    if (!rst_n) chk({nm, ".out_data_rst"}, od, 32'h0);
  endtask

  // Model update: pop the head on an output transfer, append the resolved word on an input transfer.
  always @(posedge clk) begin
    if (rst_n) begin
      bit i0, o0, i1, o1, i2, o2;
      i0 = in_valid && q0.size() < 2; o0 = out_ready && q0.size() > 0;
      i1 = in_valid && q1.size() < 2; o1 = out_ready && q1.size() > 0;
      i2 = in_valid && q2.size() < 2; o2 = out_ready && q2.size() > 0;
      if (o0) void'(q0.pop_front());
      if (o1) void'(q1.pop_front());
      if (o2) void'(q2.pop_front());
      if (i0) q0.push_back(resolve(4, 1'b0, {2'b00, sel[1:0]}, din));
      if (i1) q1.push_back(resolve(3, 1'b0, {2'b00, sel[1:0]}, din));
      if (i2) q2.push_back(resolve(4, 1'b1, sel, din));
    end
  end

  always @(negedge rst_n) begin
    q0.delete(); q1.delete(); q2.delete();
  end

  // Compare every DUT against its model in the middle of each cycle.
  always @(negedge clk) begin
    cmp("bin", ov_b, ir_b, od_b, oe_b, q0.size(), q0.size() > 0 ? q0[0] : '0);
    cmp("odd", ov_o, ir_o, od_o, oe_o, q1.size(), q1.size() > 0 ? q1[0] : '0);
    cmp("oh",  ov_h, ir_h, od_h, oe_h, q2.size(), q2.size() > 0 ? q2[0] : '0);
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  initial begin
    // Reset with in_valid high for three cycles.
    in_valid = 1'b1;
    din = {32'h44, 32'h33, 32'h22, 32'h11};
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("rst.out_valid", 32'(ov_b), 32'h0);
      chk("rst.out_data", od_b, 32'h0);
      chk("rst.out_err", 32'(oe_b), 32'h0);
      chk("rst.in_ready", 32'(ir_b), 32'h1);
    end
    in_valid = 1'b0;
    step();
    rst_n = 1'b1;

    // Back-to-back binary selects with full throughput.
    out_ready = 1'b1;
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      sel = 4'(i);
      step();
      @(negedge clk);
      chk("bin_seq.data", od_b, 32'h11 * (i + 1));
      chk("bin_seq.valid", 32'(ov_b), 32'h1);
    end
    in_valid = 1'b0;
    step(); step();

    // Backpressure fills the skid buffer.
    din = {32'h44, 32'h33, 32'hB, 32'hA};
    out_ready = 1'b0;
    in_valid = 1'b1;
    sel = 4'd0; step();
    sel = 4'd1; step();
    in_valid = 1'b0;
    @(negedge clk);
    chk("bp.in_ready_full", 32'(ir_b), 32'h0);
    chk("bp.hold_a", od_b, 32'hA);
    out_ready = 1'b1;
    step();
    @(negedge clk);
    chk("bp.second_b", od_b, 32'hB);
    chk("bp.in_ready_back", 32'(ir_b), 32'h1);
    step();
    @(negedge clk);
    chk("bp.drained", 32'(ov_b), 32'h0);

    // Illegal binary index on the 3-way instance, then a legal one.
    din = {32'h44, 32'h33, 32'h22, 32'h11};
    in_valid = 1'b1;
    sel = 4'd3; step();
    sel = 4'd1;
    @(negedge clk);
    chk("ill.err", 32'(oe_o), 32'h1);
    chk("ill.data", od_o, 32'h0);
    step();
    in_valid = 1'b0;
    @(negedge clk);
    chk("ill.next_err", 32'(oe_o), 32'h0);
    chk("ill.next_data", od_o, 32'h22);

    // One-hot select with priority and all-zero select.
    in_valid = 1'b1;
    sel = 4'b0110; step();
    sel = 4'b0000;
    @(negedge clk);
    chk("oh.prio_data", od_h, 32'h22);
    chk("oh.prio_err", 32'(oe_h), 32'h0);
    step();
    in_valid = 1'b0;
    @(negedge clk);
    chk("oh.zero_data", od_h, 32'h0);
    chk("oh.zero_err", 32'(oe_h), 32'h1);
    step();

    // Asynchronous reset while FULL, then a clean first word.
    out_ready = 1'b0;
    in_valid = 1'b1;
    sel = 4'd2; step();
    sel = 4'd3; step();
    in_valid = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    chk("arst.out_valid", 32'(ov_b), 32'h0);
    chk("arst.in_ready", 32'(ir_b), 32'h1);
    chk("arst.oh_valid", 32'(ov_h), 32'h0);
    step();
    rst_n = 1'b1;
    din = {32'h44, 32'h33, 32'h22, 32'h5A5A};
    out_ready = 1'b1;
    in_valid = 1'b1;
    sel = 4'd0; step();
    in_valid = 1'b0;
    @(negedge clk);
    chk("arst.first_data", od_b, 32'h5A5A);
    chk("arst.first_valid", 32'(ov_b), 32'h1);
    step();

    // Random traffic, checked by the model on every cycle.
    for (int c = 0; c < 10000; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      sel = 4'($urandom_range(0, 15));
      din = {$urandom, $urandom, $urandom, $urandom};
      step();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    step(); step(); step();
    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
